// File: rtl/conv_acc_quant_pkg.sv
// Shared definitions for conv_acc_quant: FSM encoding, per-channel field widths
// and output saturation limits.
package conv_acc_quant_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int SHIFT_W = 6;
    localparam int BIAS_W  = 32;

    // Saturation limits for an OUT_W-bit signed result; ReLU drops the negative range.
    function automatic longint clamp_hi(input int out_w);
        return (longint'(1) << (out_w - 1)) - 1;
    endfunction

    function automatic longint clamp_lo(input int out_w, input bit relu);
        longint lo;
        lo = relu ? longint'(0) : -(longint'(1) << (out_w - 1));
        return lo;
    endfunction

endpackage

// File: rtl/conv_acc_quant_lane.sv
// One output channel: accumulate (S2), bias add (S2), scale multiply (S3),
// round/shift/saturate into the output register (S4). Macro: CONV_ACC_QUANT_RELU_EN.
module conv_acc_quant_lane
    import conv_acc_quant_pkg::*;
#(
    parameter int PSUM_W  = 20,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int SCALE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en2,
    input  logic               en3,
    input  logic               en4,
    input  logic               first,
    input  logic [ACC_W-1:0]   rd,
    input  logic [PSUM_W-1:0]  psum,
    input  logic [BIAS_W-1:0]  bias,
    input  logic [SCALE_W-1:0] scale,
    input  logic [SHIFT_W-1:0] shift,
    output logic [ACC_W-1:0]   acc_new,
    output logic [OUT_W-1:0]   q
);

    localparam int PROD_W = ACC_W + SCALE_W + 1;
    localparam int RW     = PROD_W + 1;
`ifdef CONV_ACC_QUANT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    localparam logic signed [RW-1:0] QHI = RW'(clamp_hi(OUT_W));
    localparam logic signed [RW-1:0] QLO = RW'(clamp_lo(OUT_W, RELU));

    logic signed [ACC_W-1:0]  psum_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  s2_sum;
    logic signed [PROD_W-1:0] s3_prod;
    logic signed [RW-1:0]     rnd;
    logic signed [RW-1:0]     rounded;
    logic signed [RW-1:0]     shifted;
    logic [OUT_W-1:0]         q_nx;

    assign psum_ext = ACC_W'($signed(psum));
    assign bias_ext = ACC_W'($signed(bias));
    // Pass 0 ignores the buffer so stale contents never leak into a new tile.
    assign acc_new  = first ? psum_ext : rd + psum_ext;

    always_comb begin
        rnd = '0;
        if (shift != '0)
            rnd = RW'(1) << (shift - 1'b1);
        rounded = RW'(s3_prod) + rnd;
        shifted = rounded >>> shift;
        if (shifted > QHI)
            q_nx = QHI[OUT_W-1:0];
        else if (shifted < QLO)
            q_nx = QLO[OUT_W-1:0];
        else
            q_nx = shifted[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sum  <= '0;
            s3_prod <= '0;
            q       <= '0;
        end else begin
            if (en2)
                s2_sum <= $signed(acc_new) + bias_ext;
            if (en3)
                s3_prod <= PROD_W'(s2_sum) * PROD_W'($signed({1'b0, scale}));
            if (en4)
                q <= q_nx;
        end
    end

endmodule

// File: rtl/conv_acc_quant.sv
// Tile controller for multi-pass partial-sum accumulation with per-channel
// bias/scale/shift quantization. Macro: CONV_ACC_QUANT_RELU_EN (selects ReLU clamp in lanes).
module conv_acc_quant
    import conv_acc_quant_pkg::*;
#(
    parameter int CH_OUT  = 8,
    parameter int PSUM_W  = 20,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int SCALE_W = 16,
    parameter int DEPTH   = 256,
    parameter int PASS_W  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [PASS_W-1:0]           num_pass,
    input  logic [$clog2(DEPTH):0]      num_pix,
    input  logic [CH_OUT*BIAS_W-1:0]    bias,
    input  logic [CH_OUT*SCALE_W-1:0]   scale,
    input  logic [CH_OUT*SHIFT_W-1:0]   shift,
    input  logic [CH_OUT*PSUM_W-1:0]    s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [CH_OUT*OUT_W-1:0]     m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int PIX_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);

    state_t state, state_nx;

    logic [CH_OUT*BIAS_W-1:0]  bias_r;
    logic [CH_OUT*SCALE_W-1:0] scale_r;
    logic [CH_OUT*SHIFT_W-1:0] shift_r;
    logic [PIX_W-1:0]          pix_last_r, npix_eff;
    logic [PASS_W-1:0]         pass_last_r;
    logic [PIX_W-1:0]          pix_cnt, out_cnt;
    logic [PASS_W-1:0]         pass_cnt;

    logic stall, adv, accept, last_beat, last_out, wr_en;

    logic                       s0_valid, s0_first, s0_last;
    logic [AW-1:0]              s0_addr;
    logic [CH_OUT*PSUM_W-1:0]   s0_psum;
    logic                       s1_valid, s1_first, s1_last;
    logic [AW-1:0]              s1_addr;
    logic [CH_OUT*PSUM_W-1:0]   s1_psum;
    logic [CH_OUT*ACC_W-1:0]    s1_rd;
    logic                       s2_valid, s3_valid, s4_valid;

    logic [CH_OUT*ACC_W-1:0]    wr_data;
    logic [CH_OUT*ACC_W-1:0]    mem [DEPTH];

    assign stall     = s4_valid & ~m_ready;
    assign adv       = ~stall;
    assign s_ready   = (state == ST_RUN) & ~stall;
    assign accept    = s_valid & s_ready;
    assign last_beat = (pix_cnt == pix_last_r) && (pass_cnt == pass_last_r);
    assign last_out  = (out_cnt == pix_last_r);
    assign wr_en     = adv & s1_valid;
    assign m_valid   = s4_valid;

    always_comb begin
        if (num_pix == '0)
            npix_eff = PIX_W'(1);
        else if (num_pix > PIX_W'(DEPTH))
            npix_eff = PIX_W'(DEPTH);
        else
            npix_eff = num_pix;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE:
                if (start)
                    state_nx = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (accept && last_beat)
                    state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (m_valid && m_ready && last_out) begin
                    done     = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bias_r      <= '0;
            scale_r     <= '0;
            shift_r     <= '0;
            pix_last_r  <= '0;
            pass_last_r <= '0;
            pix_cnt     <= '0;
            pass_cnt    <= '0;
            out_cnt     <= '0;
            s0_valid    <= 1'b0;
            s0_first    <= 1'b0;
            s0_last     <= 1'b0;
            s0_addr     <= '0;
            s0_psum     <= '0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_last     <= 1'b0;
            s1_addr     <= '0;
            s1_psum     <= '0;
            s2_valid    <= 1'b0;
            s3_valid    <= 1'b0;
            s4_valid    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                bias_r      <= bias;
                scale_r     <= scale;
                shift_r     <= shift;
                pix_last_r  <= npix_eff - 1'b1;
                pass_last_r <= (num_pass == '0) ? '0 : num_pass - 1'b1;
                pix_cnt     <= '0;
                pass_cnt    <= '0;
                out_cnt     <= '0;
            end
            if (accept) begin
                if (pix_cnt == pix_last_r) begin
                    pix_cnt  <= '0;
                    pass_cnt <= (pass_cnt == pass_last_r) ? '0 : pass_cnt + 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
                s0_first <= (pass_cnt == '0);
                s0_last  <= (pass_cnt == pass_last_r);
                s0_addr  <= pix_cnt[AW-1:0];
                s0_psum  <= s_data;
            end
            if (m_valid && m_ready)
                out_cnt <= out_cnt + 1'b1;
            if (adv) begin
                s0_valid <= accept;
                s1_valid <= s0_valid;
                s1_first <= s0_first;
                s1_last  <= s0_last;
                s1_addr  <= s0_addr;
                s1_psum  <= s0_psum;
                s2_valid <= s1_valid & s1_last;
                s3_valid <= s2_valid;
                s4_valid <= s3_valid;
            end
        end
    end

    // Forward the S2 write when the next beat reads the same pixel in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[s1_addr] <= wr_data;
        if (adv)
            s1_rd <= (wr_en && s1_addr == s0_addr) ? wr_data : mem[s0_addr];
    end

    for (genvar c = 0; c < CH_OUT; c++) begin : g_lane
        conv_acc_quant_lane #(
            .PSUM_W (PSUM_W),
            .ACC_W  (ACC_W),
            .OUT_W  (OUT_W),
            .SCALE_W(SCALE_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en2    (adv & s1_valid & s1_last),
            .en3    (adv & s2_valid),
            .en4    (adv & s3_valid),
            .first  (s1_first),
            .rd     (s1_rd[c*ACC_W +: ACC_W]),
            .psum   (s1_psum[c*PSUM_W +: PSUM_W]),
            .bias   (bias_r[c*BIAS_W +: BIAS_W]),
            .scale  (scale_r[c*SCALE_W +: SCALE_W]),
            .shift  (shift_r[c*SHIFT_W +: SHIFT_W]),
            .acc_new(wr_data[c*ACC_W +: ACC_W]),
            .q      (m_data[c*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_conv_acc_quant.sv
// Directed bench for conv_acc_quant (2 channels, 8-entry buffer); expected
// values follow CONV_ACC_QUANT_RELU_EN when it is defined.
module tb_conv_acc_quant;

    localparam int CH      = 2;
    localparam int PSUM_W  = 20;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int SCALE_W = 16;
    localparam int DEPTH   = 8;
    localparam int PASS_W  = 10;
    localparam int PIX_W   = $clog2(DEPTH) + 1;
`ifdef CONV_ACC_QUANT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [PASS_W-1:0]       num_pass = '0;
    logic [PIX_W-1:0]        num_pix = '0;
    logic [CH*32-1:0]        bias = '0;
    logic [CH*SCALE_W-1:0]   scale = '0;
    logic [CH*6-1:0]         shift = '0;
    logic [CH*PSUM_W-1:0]    s_data = '0;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic [CH*OUT_W-1:0]     m_data;
    logic                    m_valid;
    logic                    m_ready = 1'b1;
    logic                    busy;
    logic                    done;

    conv_acc_quant #(
        .CH_OUT(CH), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .SCALE_W(SCALE_W), .DEPTH(DEPTH), .PASS_W(PASS_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_pass(num_pass), .num_pix(num_pix),
        .bias(bias), .scale(scale), .shift(shift),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int npass, npix;
        int p0, p1, b0, b1, sc0, sc1, sh0, sh1;
        int e0, e1, r0, r1;
    } vec_t;

    vec_t vt[8];
    logic [CH*PSUM_W-1:0] beats[$];
    int e0_q[$];
    int e1_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CH*PSUM_W-1:0] pack_psum(input int a, input int b);
        logic [PSUM_W-1:0] x, y;
        x = a[PSUM_W-1:0];
        y = b[PSUM_W-1:0];
        return {y, x};
    endfunction

    task automatic run_tile(input string tag, input int npass, input int npix,
                            input int b0, input int b1, input int sc0, input int sc1,
                            input int sh0, input int sh1, input int stall_from,
                            input int stall_len, input bit gap, input bit chk_lat);
        int bi, oi, cyc, acc_edge, stray;
        bit fin, first_out, stalled_prev, hs_s;
        logic [CH*OUT_W-1:0] prev_d;
        bi = 0; oi = 0; cyc = 0; acc_edge = -1; stray = 0;
        fin = 0; first_out = 1; stalled_prev = 0; prev_d = '0;
        num_pass = npass[PASS_W-1:0];
        num_pix  = npix[PIX_W-1:0];
        bias     = {b1, b0};
        scale    = {sc1[SCALE_W-1:0], sc0[SCALE_W-1:0]};
        shift    = {sh1[5:0], sh0[5:0]};
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        num_pass = PASS_W'($urandom);
        num_pix  = PIX_W'($urandom);
        bias     = {$urandom, $urandom};
        scale    = CH*SCALE_W'($urandom);
        shift    = CH*6'($urandom);
        while (!fin && cyc < 500) begin
            start   = (cyc == 2);
            s_valid = (bi < beats.size()) && !(gap && cyc == 3);
            s_data  = (bi < beats.size()) ? beats[bi] : '0;
            m_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            @(negedge clk);
            if (stalled_prev) begin
                chk({tag, " hold m_valid"}, m_valid, 1);
                chk({tag, " hold m_data"}, m_data, prev_d);
            end
            if (m_valid && !m_ready)
                chk({tag, " s_ready in stall"}, s_ready, 0);
            if (s_valid && s_ready && acc_edge < 0)
                acc_edge = edge_n + 1;
            if (m_valid && first_out) begin
                first_out = 0;
                if (chk_lat)
                    chk({tag, " latency"}, edge_n - acc_edge, 4);
            end
            if (m_valid && m_ready) begin
                if (oi < e0_q.size()) begin
                    chk($sformatf("%s ch0 pix%0d", tag, oi), $signed(m_data[OUT_W-1:0]), e0_q[oi]);
                    chk($sformatf("%s ch1 pix%0d", tag, oi), $signed(m_data[2*OUT_W-1:OUT_W]), e1_q[oi]);
                    chk($sformatf("%s done pix%0d", tag, oi), done, (oi == e0_q.size() - 1));
                end else begin
                    chk({tag, " extra output"}, oi, e0_q.size() - 1);
                end
                if (done) fin = 1;
                oi++;
            end else if (done) begin
                stray++;
            end
            hs_s = s_valid && s_ready;
            stalled_prev = m_valid && !m_ready;
            prev_d = m_data;
            @(posedge clk); #1;
            if (hs_s) bi++;
            cyc++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: got no done after %0d cycles", tag, cyc);
        end
        chk({tag, " output count"}, oi, e0_q.size());
        chk({tag, " beats consumed"}, bi, beats.size());
        chk({tag, " stray done"}, stray, 0);
        chk({tag, " busy after"}, busy, 0);
        chk({tag, " m_valid after"}, m_valid, 0);
    endtask

    initial begin
        int np, nx, seen;
        //        npass npix   p0    p1   b0   b1   sc0    sc1   sh0 sh1  e0    e1   r0   r1
        vt[0] = '{1,    4,     10,   10,  0,   0,   1,     1,    0,  0,   10,   10,  10,  10};
        vt[1] = '{3,    2,     100, -20, -50,  0,   3,     1,    2,  0,   127, -60,  127, 0};
        vt[2] = '{4,    1,     5,    7,   0,   3,   1,     1,    0,  0,   20,   31,  20,  31};
        vt[3] = '{1,    3,    -40,  -10,  0,  -30,  1,     1,    0,  0,  -40,  -40,  0,   0};
        vt[4] = '{0,    0,     9,    3,   1,   0,   2,     5,    1,  0,   10,   15,  10,  15};
        vt[5] = '{2,    10,    50,  -100, 0,   0,   2,     1,    0,  0,   127, -128, 127, 0};
        vt[6] = '{1,    2,    -5,    6,   0,   0,   1,     1,    1,  2,  -2,    2,   0,   2};
        vt[7] = '{2,    3,     1000,-1000,24, -24,  65535, 65535,20, 20,  126, -126, 126, 0};

        #1;
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset s_ready", s_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            np = (vt[i].npass == 0) ? 1 : vt[i].npass;
            nx = (vt[i].npix == 0) ? 1 : ((vt[i].npix > DEPTH) ? DEPTH : vt[i].npix);
            beats.delete(); e0_q.delete(); e1_q.delete();
            for (int k = 0; k < np * nx; k++) beats.push_back(pack_psum(vt[i].p0, vt[i].p1));
            for (int k = 0; k < nx; k++) begin
                e0_q.push_back(RELU ? vt[i].r0 : vt[i].e0);
                e1_q.push_back(RELU ? vt[i].r1 : vt[i].e1);
            end
            run_tile($sformatf("vec%0d", i), vt[i].npass, vt[i].npix, vt[i].b0, vt[i].b1,
                     vt[i].sc0, vt[i].sc1, vt[i].sh0, vt[i].sh1, 1000, 0, 1'b0, (i == 0));
        end

        // distinct per-pixel sums, input bubble and a 5-cycle output stall while still in RUN
        beats.delete(); e0_q.delete(); e1_q.delete();
        for (int p = 0; p < 2; p++)
            for (int x = 0; x < 8; x++)
                beats.push_back(pack_psum((x + 1) * (p + 1), -(x + 1) * 4));
        for (int x = 0; x < 8; x++) begin
            e0_q.push_back(3 * (x + 1));
            e1_q.push_back(RELU ? 0 : -8 * (x + 1));
        end
        run_tile("stall", 2, 8, 0, 0, 1, 1, 0, 0, 15, 5, 1'b1, 1'b0);

        // abandon a tile during pass 1
        num_pass = 3; num_pix = 4; bias = '0; scale = {16'd1, 16'd1}; shift = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = pack_psum(77, 77);
        m_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst m_valid", m_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst s_ready", s_ready, 0);
        chk("midrst done", done, 0);
        chk("midrst m_data", m_data, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_valid || busy || s_ready) seen++;
        end
        chk("post-reset quiet", seen, 0);
        s_valid = 1'b0;
        @(posedge clk); #1;

        beats.delete(); e0_q.delete(); e1_q.delete();
        for (int k = 0; k < 8; k++) beats.push_back(pack_psum(11, -3));
        for (int k = 0; k < 4; k++) begin
            e0_q.push_back(24);
            e1_q.push_back(RELU ? 0 : -6);
        end
        run_tile("fresh", 2, 4, 2, 0, 1, 1, 0, 0, 1000, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_acc_quant.md
CONV_ACC_QUANT -- requirements
Module: conv_acc_quant

Interface
REQ-001 SHALL have parameter CH_OUT, default 8: output channels processed in parallel.
REQ-002 SHALL have parameter PSUM_W, default 20: signed partial-sum width per channel.
REQ-003 SHALL have parameter ACC_W, default 32: signed accumulator width.
REQ-004 SHALL have parameter OUT_W, default 8: quantized output width.
REQ-005 SHALL have parameter SCALE_W, default 16: unsigned scale width.
REQ-006 SHALL have parameter DEPTH, default 256: accumulation buffer entries (pixels per tile).
REQ-007 SHALL have parameter PASS_W, default 10: channel-in pass counter width.
REQ-008 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-009 start  in  1  one-cycle pulse; samples configuration and begins a tile.
REQ-010 num_pass  in  PASS_W  channel-in passes per tile.
REQ-011 num_pix  in  $clog2(DEPTH)+1  pixels per pass.
REQ-012 bias  in  CH_OUT*32  signed per-channel bias; scale  in  CH_OUT*SCALE_W; shift  in  CH_OUT*6.
REQ-013 s_data  in  CH_OUT*PSUM_W; s_valid  in  1; s_ready  out  1.
REQ-014 m_data  out  CH_OUT*OUT_W; m_valid  out  1; m_ready  in  1.
REQ-015 busy  out  1  tile in progress; done  out  1  one-cycle pulse after last output handshake.

Function
REQ-016 States IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on acceptance of last beat (last pass, last pixel); DRAIN->IDLE on last m_valid&m_ready, asserting done that cycle.
REQ-017 start outside IDLE SHALL be ignored; num_pass=0 or num_pix=0 SHALL be treated as 1; num_pix>DEPTH SHALL be clamped to DEPTH.
REQ-018 bias/scale/shift/num_pass/num_pix SHALL be registered at start and held for the tile.
REQ-019 Beat accepted when s_valid&s_ready; pixel counter increments per beat, wraps at num_pix-1 and increments pass counter.
REQ-020 Pass 0 SHALL write sign-extended psum; passes 1..num_pass-1 SHALL read-add-write buffer entry at pixel index.
REQ-021 Read-after-write on same address in adjacent cycles (num_pix=1) SHALL forward write data, never stale buffer data.
REQ-022 Last-pass beats SHALL proceed to quantization: y = (acc+bias)*scale, add 2^(shift-1) when shift>0, arithmetic shift right by shift, then clamp.
REQ-023 Accumulation SHALL wrap modulo 2^ACC_W; product SHALL be full width ACC_W+SCALE_W+1.
REQ-024 Pipeline: S1 buffer read, S2 add/bias, S3 multiply, S4 round/shift/clamp into output register; latency accept->m_valid = 4 cycles without stall.
REQ-025 Stall = m_valid & ~m_ready; all stages hold on stall; s_ready = (state==RUN) & ~stall.
REQ-026 m_data SHALL stay stable while m_valid & ~m_ready; outputs in pixel order.

Reset
REQ-027 rst SHALL asynchronously force IDLE, counters 0, s_ready=0, m_valid=0, m_data=0, busy=0, done=0; buffer contents undefined (pass 0 overwrites).
REQ-028 rst mid-tile SHALL abandon the tile; no output after reset release until new start.

Configuration
REQ-029 Macro CONV_ACC_QUANT_RELU_EN: defined -> clamp to [0, 2^(OUT_W-1)-1] (ReLU); undefined -> signed clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Structure
REQ-030 Package conv_acc_quant_pkg SHALL hold state encoding, shift width (6), rounding/clamp constants.
REQ-031 Per-channel S2-S4 datapath SHALL be sub-module conv_acc_quant_lane, instantiated CH_OUT times.

Verification
REQ-032 num_pass=1,num_pix=4, psum=10, bias=0, scale=1, shift=0 -> m_data channel=10 at 4 cycles, done after 4th handshake.
REQ-033 num_pass=3,num_pix=2, psum=100 each pass, bias=-50, scale=3, shift=2 -> (250*3+2)>>2 = 188 -> clamp 127.
REQ-034 num_pix=1, num_pass=4, psum=5 back-to-back -> acc=20, confirms forwarding.
REQ-035 m_ready low 5 cycles mid-tile -> s_ready low, m_data stable, no loss/duplication.
REQ-036 acc+bias=-40, scale=1, shift=0 -> -40 without RELU_EN, 0 with RELU_EN.
REQ-037 rst pulse in RUN pass 1 -> IDLE, m_valid=0; fresh start yields correct results.
